receptor: RTL and testbench

RECEPTOR -- requirements
Module: receptor

---
 rtl/receptor_pkg.sv | 45 ++++
 rtl/receptor_unstriping.sv | 44 ++++
 rtl/receptor.sv | 132 +++++++++++++
 tb/tb_receptor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/receptor_pkg.sv
// rtl/receptor_pkg.sv - symbol byte values and control codes shared by receptor and transmitter mux
package receptor_pkg;

  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_SKP  = 8'h1C;
  localparam logic [7:0] SYM_STP  = 8'hFB;
  localparam logic [7:0] SYM_SDP  = 8'h5C;
  localparam logic [7:0] SYM_END  = 8'hFD;
  localparam logic [7:0] SYM_EDB  = 8'hFE;
  localparam logic [7:0] SYM_FTS  = 8'h3C;
  localparam logic [7:0] SYM_IDLE = 8'h7C;

  // Same numbering as the transmitter's control_dk
  typedef enum logic [3:0] {
    CTRL_DATA = 4'd0,
    CTRL_COM  = 4'd1,
    CTRL_SKP  = 4'd2,
    CTRL_STP  = 4'd3,
    CTRL_SDP  = 4'd4,
    CTRL_END  = 4'd5,
    CTRL_EDB  = 4'd6,
    CTRL_FTS  = 4'd7,
    CTRL_IDLE = 4'd8
  } ctrl_code_t;

  typedef enum logic {
    OUT_PKT = 1'b0,
    IN_PKT  = 1'b1
  } frame_state_t;

  function automatic ctrl_code_t classify(input logic [7:0] b);
    case (b)
      SYM_COM:  classify = CTRL_COM;
      SYM_SKP:  classify = CTRL_SKP;
      SYM_STP:  classify = CTRL_STP;
      SYM_SDP:  classify = CTRL_SDP;
      SYM_END:  classify = CTRL_END;
      SYM_EDB:  classify = CTRL_EDB;
      SYM_FTS:  classify = CTRL_FTS;
      SYM_IDLE: classify = CTRL_IDLE;
      default:  classify = CTRL_DATA;
    endcase
  endfunction

endpackage

// File: rtl/receptor_unstriping.sv
// rtl/receptor_unstriping.sv - one-word holding buffer issuing lane0..lane3 one byte per enabled cycle
module receptor_unstriping (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] rx_lane0,
  input  logic [7:0] rx_lane1,
  input  logic [7:0] rx_lane2,
  input  logic [7:0] rx_lane3,
  input  logic       rx_ValidE,
  output logic       rx_Ready,
  output logic       issue_valid,
  output logic [7:0] issue_byte
);

  logic [3:0][7:0] hold;
  logic            full;
  logic [1:0]      ptr;
  logic            accept;

  // Reloading while lane3 leaves keeps words back-to-back without a bubble
  assign rx_Ready    = rst & enb & (~full | (ptr == 2'd3));
  assign accept      = rx_Ready & rx_ValidE;
  assign issue_valid = enb & full;
  assign issue_byte  = hold[ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      full <= 1'b0;
      ptr  <= 2'd0;
    end else if (accept) begin
      hold <= {rx_lane3, rx_lane2, rx_lane1, rx_lane0};
      full <= 1'b1;
      ptr  <= 2'd0;
    end else if (issue_valid) begin
      ptr <= ptr + 2'd1;
      if (ptr == 2'd3) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/receptor.sv
// rtl/receptor.sv - unstripes four-lane words and frames packets from the control-symbol stream
module receptor (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] rx_lane0,
  input  logic [7:0] rx_lane1,
  input  logic [7:0] rx_lane2,
  input  logic [7:0] rx_lane3,
  input  logic       rx_ValidE,
  output logic       rx_Ready,
  output logic [7:0] rx_DataS,
  output logic       rx_ValidS,
  output logic [3:0] rx_CtrlS,
  output logic       rx_CtrlValid,
  output logic       rx_PktStart,
  output logic       rx_PktEnd,
  output logic       rx_PktBad,
  output logic       rx_Err
);
  import receptor_pkg::*;

  frame_state_t state, state_nxt;
  logic         issue_valid;
  logic [7:0]   issue_byte;
  ctrl_code_t   code;

  logic [7:0] data_nxt;
  logic [3:0] ctrl_nxt;
  logic       valid_nxt, cv_nxt, start_nxt, end_nxt, bad_nxt, err_nxt;

  receptor_unstriping unstriping (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .rx_lane0    (rx_lane0),
    .rx_lane1    (rx_lane1),
    .rx_lane2    (rx_lane2),
    .rx_lane3    (rx_lane3),
    .rx_ValidE   (rx_ValidE),
    .rx_Ready    (rx_Ready),
    .issue_valid (issue_valid),
    .issue_byte  (issue_byte)
  );

  assign code = classify(issue_byte);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= OUT_PKT;
    end else begin
      state <= state_nxt;
    end
  end

  // Without an issued byte everything holds and every pulse/valid drops
  always_comb begin
    state_nxt = state;
    data_nxt  = rx_DataS;
    ctrl_nxt  = rx_CtrlS;
    valid_nxt = 1'b0;
    cv_nxt    = 1'b0;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    bad_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (issue_valid) begin
      ctrl_nxt = code;
      case (state)
        OUT_PKT: begin
          case (code)
            CTRL_STP, CTRL_SDP: begin
              state_nxt = IN_PKT;
              start_nxt = 1'b1;
              cv_nxt    = 1'b1;
            end
            CTRL_COM, CTRL_SKP, CTRL_FTS, CTRL_IDLE: cv_nxt = 1'b1;
            default: err_nxt = 1'b1;
          endcase
        end
        IN_PKT: begin
          case (code)
            CTRL_END: begin
              state_nxt = OUT_PKT;
              end_nxt   = 1'b1;
              cv_nxt    = 1'b1;
            end
            CTRL_EDB: begin
              state_nxt = OUT_PKT;
              end_nxt   = 1'b1;
              bad_nxt   = 1'b1;
              cv_nxt    = 1'b1;
            end
            CTRL_STP, CTRL_SDP: begin
              err_nxt   = 1'b1;
              start_nxt = 1'b1;
              cv_nxt    = 1'b1;
            end
            default: begin
              ctrl_nxt  = CTRL_DATA;
              data_nxt  = issue_byte;
              valid_nxt = 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_DataS     <= 8'h00;
      rx_CtrlS     <= 4'd0;
      rx_ValidS    <= 1'b0;
      rx_CtrlValid <= 1'b0;
      rx_PktStart  <= 1'b0;
      rx_PktEnd    <= 1'b0;
      rx_PktBad    <= 1'b0;
      rx_Err       <= 1'b0;
    end else begin
      rx_DataS     <= data_nxt;
      rx_CtrlS     <= ctrl_nxt;
      rx_ValidS    <= valid_nxt;
      rx_CtrlValid <= cv_nxt;
      rx_PktStart  <= start_nxt;
      rx_PktEnd    <= end_nxt;
      rx_PktBad    <= bad_nxt;
      rx_Err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_receptor.sv
// tb/tb_receptor.sv - directed scoreboard bench for receptor
module tb_receptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [7:0] rx_lane0, rx_lane1, rx_lane2, rx_lane3;
  logic       rx_ValidE;
  logic       rx_Ready;
  logic [7:0] rx_DataS;
  logic       rx_ValidS;
  logic [3:0] rx_CtrlS;
  logic       rx_CtrlValid;
  logic       rx_PktStart, rx_PktEnd, rx_PktBad, rx_Err;

  always #5 clk = ~clk;

  receptor dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .rx_lane0     (rx_lane0),
    .rx_lane1     (rx_lane1),
    .rx_lane2     (rx_lane2),
    .rx_lane3     (rx_lane3),
    .rx_ValidE    (rx_ValidE),
    .rx_Ready     (rx_Ready),
    .rx_DataS     (rx_DataS),
    .rx_ValidS    (rx_ValidS),
    .rx_CtrlS     (rx_CtrlS),
    .rx_CtrlValid (rx_CtrlValid),
    .rx_PktStart  (rx_PktStart),
    .rx_PktEnd    (rx_PktEnd),
    .rx_PktBad    (rx_PktBad),
    .rx_Err       (rx_Err)
  );

  typedef struct packed {
    logic [17:0] exp;
    int          stamp;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   w;
  logic in_pkt_m;

  function automatic logic [17:0] pack(input logic vs, input logic [7:0] data, input logic [3:0] ctrl,
                                       input logic cv, input logic st, input logic en,
                                       input logic bd, input logic er);
    return {vs, vs ? data : 8'h00, (vs | cv) ? ctrl : 4'h0, cv, st, en, bd, er};
  endfunction

  function automatic logic [3:0] code_of(input logic [7:0] b);
    case (b)
      8'hBC:   return 4'd1;
      8'h1C:   return 4'd2;
      8'hFB:   return 4'd3;
      8'h5C:   return 4'd4;
      8'hFD:   return 4'd5;
      8'hFE:   return 4'd6;
      8'h3C:   return 4'd7;
      8'h7C:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [17:0] model(input logic [7:0] b);
    logic [3:0] c;
    c = code_of(b);
    if (!in_pkt_m) begin
      if (c == 4'd3 || c == 4'd4) begin
        in_pkt_m = 1'b1;
        return pack(1'b0, 8'h00, c, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      if (c == 4'd1 || c == 4'd2 || c == 4'd7 || c == 4'd8)
        return pack(1'b0, 8'h00, c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      return pack(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    if (c == 4'd5) begin
      in_pkt_m = 1'b0;
      return pack(1'b0, 8'h00, c, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    if (c == 4'd6) begin
      in_pkt_m = 1'b0;
      return pack(1'b0, 8'h00, c, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    if (c == 4'd3 || c == 4'd4)
      return pack(1'b0, 8'h00, c, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    return pack(1'b1, b, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [31:0] wd(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    logic [17:0] obs;
    rec_t        r;
    if (rx_ValidS | rx_CtrlValid | rx_Err | rx_PktStart | rx_PktEnd | rx_PktBad) begin
      obs = pack(rx_ValidS, rx_DataS, rx_CtrlS, rx_CtrlValid, rx_PktStart, rx_PktEnd, rx_PktBad, rx_Err);
      if (sb.size() == 0) begin
        check("unexpected_event", {14'h0, obs}, 32'h0);
      end else begin
        r = sb.pop_front();
        check("byte_out", {14'h0, obs}, {14'h0, r.exp});
        if (r.stamp >= 0) check("byte_latency", cyc, r.stamp);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_out();
  endtask

  // gap delays bytes 2 and 3 by that many frozen cycles
  task automatic send_word(input logic [31:0] word, input int gap, output int waited);
    rec_t       r;
    logic [7:0] b;
    rx_lane0  = word[7:0];
    rx_lane1  = word[15:8];
    rx_lane2  = word[23:16];
    rx_lane3  = word[31:24];
    rx_ValidE = 1'b1;
    waited    = 0;
    while (!rx_Ready && waited < 20) begin
      cycle();
      waited++;
    end
    if (!rx_Ready) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      for (int k = 0; k < 4; k++) begin
        b       = word[8*k +: 8];
        r.exp   = model(b);
        r.stamp = cyc + 2 + k + ((k >= 2) ? gap : 0);
        sb.push_back(r);
      end
      cycle();
    end
    rx_ValidE = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 16) begin
      cycle();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  function automatic logic [31:0] all_outs();
    return {13'h0, rx_Ready, rx_ValidS, rx_CtrlValid, rx_PktStart, rx_PktEnd, rx_PktBad, rx_Err,
            rx_DataS, rx_CtrlS};
  endfunction

  initial begin
    in_pkt_m  = 1'b0;
    rst       = 1'b0;
    enb       = 1'b1;
    rx_ValidE = 1'b0;
    rx_lane0  = 8'h00;
    rx_lane1  = 8'h00;
    rx_lane2  = 8'h00;
    rx_lane3  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 32'h0);

    rst = 1'b1;
    #1 check("ready_after_reset", {31'h0, rx_Ready}, 32'd1);
    @(negedge clk);

    send_word(wd(8'hFB, 8'h11, 8'h22, 8'h33), 0, w);
    check("first_word_wait", w, 0);
    send_word(wd(8'h44, 8'hFD, 8'h7C, 8'h7C), 0, w);
    check("back_to_back_wait", w, 3);
    send_word(wd(8'h5C, 8'hAA, 8'hFE, 8'hBC), 0, w);
    check("bad_pkt_wait", w, 3);
    send_word(wd(8'h12, 8'hFD, 8'h1C, 8'h3C), 0, w);
    check("out_pkt_err_wait", w, 3);
    send_word(wd(8'hFB, 8'hBC, 8'hFB, 8'hFD), 0, w);
    check("restart_wait", w, 3);
    drain("drain_main");
    repeat (3) cycle();
    check("ready_idle", {31'h0, rx_Ready}, 32'd1);

    send_word(wd(8'hFB, 8'h01, 8'h02, 8'hFD), 3, w);
    cycle();
    cycle();
    enb       = 1'b0;
    rx_ValidE = 1'b1;
    rx_lane0  = 8'hBC;
    rx_lane1  = 8'hBC;
    rx_lane2  = 8'hBC;
    rx_lane3  = 8'hBC;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("freeze_outputs", {rx_Ready, rx_ValidS, rx_CtrlValid, rx_PktStart, rx_PktEnd, rx_PktBad,
                               rx_Err, rx_DataS}, {7'h0, 8'h01});
    end
    enb       = 1'b1;
    rx_ValidE = 1'b0;
    drain("drain_freeze");

    send_word(wd(8'hFB, 8'h01, 8'h02, 8'h03), 0, w);
    cycle();
    cycle();
    rst = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 32'h0);
    sb.delete();
    in_pkt_m = 1'b0;
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b1;
    repeat (4) cycle();
    send_word(wd(8'hBC, 8'h1C, 8'h3C, 8'h7C), 0, w);
    check("post_reset_wait", w, 0);
    drain("drain_post_reset");
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
